// File: rtl/wave_capture_pkg.sv
// Shared definitions for the wave_capture acquisition block.
//   state_e   : acquisition FSM states
//   EDGE_*    : values of the trig_edge input
//   trig_hit  : level-crossing test between two consecutive stored samples
package wave_capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Rising: prev below level and cur at/above it.
  // Falling: prev above level and cur at/below it.
  function automatic logic trig_hit(input logic [7:0] prev,
                                    input logic [7:0] cur,
                                    input logic [7:0] level,
                                    input logic       edge_sel);
    logic hit;
    if (edge_sel == EDGE_RISE) hit = (prev < level) && (cur >= level);
    else                       hit = (prev > level) && (cur <= level);
    return hit;
  endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Simple dual-port sample store, DEPTH x 8.
//   clk    : clock
//   rst    : synchronous active-high reset (read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : registered read data, one cycle after raddr
// The array itself has no reset so it maps onto block RAM; only the read
// register is cleared.
module capture_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wave_capture.sv
// Oscilloscope acquisition: decimates the 8-bit sample stream, captures a
// circular pre/post-trigger record and serves it through a read port indexed
// from the oldest sample of the record.
//   clk100      : system clock
//   clr         : synchronous active-high reset
//   din         : sample input, taken only on the internal strobe
//   samp_div    : strobe every samp_div+1 cycles
//   trig_level  : trigger threshold
//   trig_edge   : 0 rising, 1 falling
//   auto_mode   : force a trigger after AUTO_TIMEOUT waiting samples
//   arm         : pulse, starts/restarts an acquisition
//   rd_addr     : record-relative read index (0 = oldest)
//   rd_data     : registered read data
//   busy        : PRE, WAIT_TRIG or POST
//   done        : record complete
//   trig_forced : last record was closed by the auto timeout
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter  int DEPTH        = 512,
  parameter  int PRETRIG      = 128,
  parameter  int AUTO_TIMEOUT = 4096,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk100,
  input  logic          clr,
  input  logic [7:0]    din,
  input  logic [15:0]   samp_div,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic          auto_mode,
  input  logic          arm,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          trig_forced
);

  localparam int           TW      = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(AUTO_TIMEOUT - 1);
  localparam logic [AW-1:0] PRE_LAST = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] PRE_LEN  = AW'(PRETRIG);

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    prev_q, prev_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          trig_forced_q, trig_forced_d;

  logic strobe;
  logic hit;
  logic timeout;
  logic capturing;
  logic we;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    wr_ptr_d      = wr_ptr_q;
    start_ptr_d   = start_ptr_q;
    to_cnt_d      = to_cnt_q;
    prev_d        = prev_q;
    trig_forced_d = trig_forced_q;
    we            = 1'b0;

    // div_q is reloaded only at a wrap, so a samp_div change never cuts a
    // period short.
    strobe = (cnt_q == div_q);
    if (strobe) begin
      cnt_d = '0;
      div_d = samp_div;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    hit       = trig_hit(prev_q, din, trig_level, trig_edge);
    timeout   = auto_mode && (to_cnt_q == TO_LAST);
    capturing = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);

    if (arm) begin
      state_d       = PRE;
      cnt_d         = '0;
      div_d         = samp_div;
      wr_ptr_d      = '0;
      to_cnt_d      = '0;
      trig_forced_d = 1'b0;
    end else if (strobe && capturing) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      prev_d   = din;
      case (state_q)
        // wr_ptr starts at 0 on arm, so it doubles as the PRE sample count.
        PRE: if (wr_ptr_q == PRE_LAST) state_d = WAIT_TRIG;
        WAIT_TRIG: begin
          if (hit || timeout) begin
            state_d       = POST;
            start_ptr_d   = wr_ptr_q - PRE_LEN;
            trig_forced_d = !hit;
          end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        // The record's last slot sits just before its first one.
        POST: if (wr_ptr_q == start_ptr_q - AW'(1)) state_d = DONE;
        default: ;
      endcase
    end

    busy_d = (state_d == PRE) || (state_d == WAIT_TRIG) || (state_d == POST);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk100) begin
    if (clr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      wr_ptr_q      <= '0;
      start_ptr_q   <= '0;
      to_cnt_q      <= '0;
      prev_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      trig_forced_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      wr_ptr_q      <= wr_ptr_d;
      start_ptr_q   <= start_ptr_d;
      to_cnt_q      <= to_cnt_d;
      prev_q        <= prev_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      trig_forced_q <= trig_forced_d;
    end
  end

  capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk100),
    .rst   (clr),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (start_ptr_q + rd_addr),
    .rdata (rd_data)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign trig_forced = trig_forced_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture (DEPTH 512, PRETRIG 128, AUTO_TIMEOUT 4096).
// din is driven from a tick count restarted at each arm so that the sample
// taken at the first strobe after a samp_div=0 arm is f(0).
module tb_wave_capture;

  localparam int DEPTH        = 512;
  localparam int PRETRIG      = 128;
  localparam int AUTO_TIMEOUT = 4096;
  localparam int AW           = 9;

  // din generators
  localparam int M_CONST  = 0;  // constant 50
  localparam int M_RAMP   = 1;  // t mod 256
  localparam int M_SQUARE = 2;  // 255 for 32 ticks, then 0 for 32 ticks

  logic          clk100 = 1'b0;
  logic          clr;
  logic [7:0]    din;
  logic [15:0]   samp_div;
  logic [7:0]    trig_level;
  logic          trig_edge;
  logic          auto_mode;
  logic          arm;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          trig_forced;

  int n_cmp = 0;
  int n_err = 0;
  int tick  = 0;
  int mode  = M_RAMP;
  int n_steps;
  logic [7:0] exp_q[$];

  always #5 clk100 = ~clk100;

  wave_capture #(.DEPTH(DEPTH), .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)) dut (
    .clk100      (clk100),
    .clr         (clr),
    .din         (din),
    .samp_div    (samp_div),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .auto_mode   (auto_mode),
    .arm         (arm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .trig_forced (trig_forced)
  );

  function automatic logic [7:0] gen(input int m, input int t);
    logic [7:0] v;
    case (m)
      M_RAMP:   v = 8'(t % 256);
      M_SQUARE: v = ((t % 64) < 32) ? 8'd255 : 8'd0;
      default:  v = 8'd50;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk100);
    din = gen(mode, tick);
    tick++;
  endtask

  // Leaves us just after the edge that sampled arm, with din = gen(mode, 0).
  task automatic do_arm();
    @(negedge clk100);
    arm = 1'b1;
    @(negedge clk100);
    arm  = 1'b0;
    tick = 0;
    din  = gen(mode, 0);
    tick = 1;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic read_one(input string tag, input int addr, input logic [7:0] expv);
    @(negedge clk100);
    rd_addr = AW'(addr);
    @(negedge clk100);
    check(tag, rd_data, expv);
  endtask

  // Back-to-back reads over the whole record; record index i holds the
  // sample driven at tick t0 + stride*i.
  task automatic sweep(input string tag, input int t0, input int stride);
    logic [7:0] e;
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk100);
      if (i > 0) begin
        e = exp_q.pop_front();
        check(tag, rd_data, e);
      end
      if (i < DEPTH) begin
        rd_addr = AW'(i);
        exp_q.push_back(gen(mode, t0 + stride * i));
      end
    end
  endtask

  initial begin
    clr        = 1'b1;
    din        = '0;
    samp_div   = '0;
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    auto_mode  = 1'b0;
    arm        = 1'b0;
    rd_addr    = '0;
    repeat (3) @(negedge clk100);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_forced", trig_forced, 0);
    check("reset_rd_data", rd_data, 0);
    clr = 1'b0;

    // Ramp, rising at 100: the PRE crossing is ignored, trigger at tick 356.
    mode = M_RAMP;
    do_arm();
    check("ramp_busy_after_arm", busy, 1);
    check("ramp_done_after_arm", done, 0);
    wait_done(20000, n_steps);
    check("ramp_done_latency", n_steps, 740);
    check("ramp_busy_at_done", busy, 0);
    check("ramp_forced", trig_forced, 0);
    read_one("ramp_rd128", 128, 8'd100);
    read_one("ramp_rd0", 0, 8'd228);
    read_one("ramp_rd511", 511, 8'd227);
    sweep("ramp_sweep", 228, 1);

    // Square wave, falling at 128: first 255->0 step in WAIT_TRIG is tick 160.
    mode       = M_SQUARE;
    trig_level = 8'd128;
    trig_edge  = 1'b1;
    do_arm();
    wait_done(20000, n_steps);
    check("fall_done_latency", n_steps, 544);
    check("fall_forced", trig_forced, 0);
    read_one("fall_rd128", 128, 8'd0);
    read_one("fall_rd127", 127, 8'd255);

    // Constant 50, never crosses 100: auto trigger closes the record.
    mode       = M_CONST;
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    auto_mode  = 1'b1;
    do_arm();
    wait_done(20000, n_steps);
    check("auto_done_latency", n_steps, PRETRIG + AUTO_TIMEOUT + 383);
    check("auto_forced", trig_forced, 1);
    sweep("auto_sweep", 0, 0);

    // Same stimulus without auto: waits forever; arm clears trig_forced.
    auto_mode = 1'b0;
    do_arm();
    check("noauto_forced_cleared", trig_forced, 0);
    repeat (10000) step();
    check("noauto_busy", busy, 1);
    check("noauto_done", done, 0);

    // Re-arm from WAIT_TRIG with the ramp: a full fresh PRE precedes the trigger.
    mode = M_RAMP;
    do_arm();
    check("rearm_done", done, 0);
    check("rearm_busy", busy, 1);
    wait_done(20000, n_steps);
    check("rearm_done_latency", n_steps, 740);
    read_one("rearm_rd128", 128, 8'd100);

    // Decimation by 4: strobes take ticks 3, 7, 11, ...; trigger on 99->103.
    samp_div = 16'd3;
    do_arm();
    wait_done(20000, n_steps);
    check("decim_done_latency", n_steps, 2148);
    read_one("decim_rd128", 128, 8'd103);
    sweep("decim_sweep", 103, 4);

    // clr in POST: outputs return to reset values on the next cycle.
    samp_div = 16'd0;
    do_arm();
    repeat (500) step();
    check("clr_pre_busy", busy, 1);
    check("clr_pre_done", done, 0);
    @(negedge clk100);
    clr = 1'b1;
    @(negedge clk100);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_forced", trig_forced, 0);
    check("clr_rd_data", rd_data, 0);
    clr = 1'b0;
    repeat (20) step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
# wave_capture

Acquisition end of the on-board oscilloscope path. Consumes the 8-bit sample stream produced by the waveform generator (or the ADC front end), decimates it by a programmable divider, and detects a level/edge trigger. It stores a pre/post-trigger record in a circular block RAM and presents the completed record to the display logic through a synchronous read port addressed relative to record start.

## Interface
- DEPTH, 512: record length in samples; power of two, ≥ 4.
- PRETRIG, 128: samples kept before the trigger sample; 1 ≤ PRETRIG ≤ DEPTH-2.
- AUTO_TIMEOUT, 4096: samples taken in WAIT_TRIG before a forced trigger in auto mode; ≥ 1.
- clk100  in  1  system clock, 100 MHz.
- clr  in  1  synchronous active-high reset.
- din  in  8  unsigned sample input, sampled only on the internal strobe.
- samp_div  in  16  decimation; strobe every samp_div+1 cycles (0 = every cycle).
- trig_level  in  8  unsigned trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- auto_mode  in  1  1 = force a trigger after AUTO_TIMEOUT samples.
- arm  in  1  single-cycle pulse; starts or restarts an acquisition.
- rd_addr  in  log2(DEPTH)  read index relative to record start (0 = oldest).
- rd_data  out  8  registered read data.
- busy  out  1  acquisition in progress (PRE, WAIT_TRIG or POST).
- done  out  1  record complete and stable.
- trig_forced  out  1  the last record was closed by auto timeout.

## Operation
- States: IDLE → PRE → WAIT_TRIG → POST → DONE. DONE persists until arm or clr.
- Strobe counter: counts 0..samp_div, strobe when count == samp_div, then wraps to 0. It is cleared on arm. samp_div is sampled live; a change takes effect at the next wrap.
- On each strobe in PRE/WAIT_TRIG/POST, din is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH. wr_ptr is cleared on arm.
- PRE: write exactly PRETRIG samples, then enter WAIT_TRIG. No trigger is evaluated in PRE, but prev_sample is updated.
- WAIT_TRIG: writing continues circularly. Each stored sample cur is compared with prev_sample.
  - Rising trigger: prev < trig_level and cur ≥ trig_level.
  - Falling trigger: prev > trig_level and cur ≤ trig_level.
- The trigger sample is the one just written; trig_ptr is its address, and start_ptr = trig_ptr − PRETRIG mod DEPTH.
- Timeout counter: counts samples taken in WAIT_TRIG. If auto_mode is set and the AUTO_TIMEOUT-th sample produces no real trigger, that sample becomes a forced trigger and trig_forced is set to 1.
  - A real trigger on the same sample wins; trig_forced is then 0.
  - With auto_mode = 0, the block waits indefinitely.
- POST: write DEPTH−PRETRIG−1 further samples, then enter DONE. The record then covers start_ptr .. start_ptr+DEPTH−1, with the trigger sample at rd_addr = PRETRIG.
- Read port: rd_data <= mem[(start_ptr + rd_addr) mod DEPTH] every cycle, in any state. Contents are meaningful only while done = 1.
- arm in any state, including mid-acquisition and DONE:
  - go to PRE;
  - clear wr_ptr, the strobe counter, the timeout counter, done and trig_forced.
  - Memory is not cleared.
- clr takes priority over arm.

## Timing
- Reset values:
  - state IDLE; busy, done, trig_forced = 0; rd_data = 0;
  - wr_ptr, start_ptr and all counters = 0.
- busy is a registered output. It rises on the cycle after arm and falls on the same edge at which done rises.
- done rises the cycle after the final POST write. The next cycle's read returns that final sample.
- Read latency: 1 cycle, rd_addr to rd_data. Continuous back-to-back reads are allowed.
- Trigger detection adds no latency: the state transition to POST occurs at the strobe edge that writes the trigger sample.
- Minimum acquisition time: DEPTH strobes after arm (trigger on the first WAIT_TRIG sample).

## Structure
- Shared package holds:
  - the state enum (IDLE, PRE, WAIT_TRIG, POST, DONE);
  - the edge-select constants EDGE_RISE = 0 and EDGE_FALL = 1.
- Sub-module capture_ram: simple dual-port RAM (write port, synchronous read port), DEPTH × 8, inferred as BRAM.
- The control FSM, strobe divider and trigger comparator stay in wave_capture.

## Test plan
All scenarios use DEPTH = 512 and PRETRIG = 128, with arm pulsed once after reset.
- **Ramp trigger.** din = 8-bit ramp starting at 0 at arm, +1 per cycle; samp_div = 0; rising edge, trig_level = 100.
  - PRE holds 0..127, and the crossing at value 100 is ignored.
  - Trigger on the next 99→100 step; done follows 383 samples later.
  - Reads: rd_addr 128 → 100, rd_addr 0 → 228, rd_addr 511 → 227; trig_forced = 0.
- **Falling edge.** din = square wave, 0/255, period 64; trig_level = 128, falling edge.
  - rd_addr 128 → 0, rd_addr 127 → 255.
- **Auto timeout.** din constant 50, auto_mode = 1, AUTO_TIMEOUT = 4096.
  - done after 128 + 4096 + 383 strobes; trig_forced = 1; every address reads 50.
  - Same stimulus with auto_mode = 0: busy = 1 and done = 0 after 10000 cycles.
- **Decimation.** samp_div = 3 with the ramp of the first scenario.
  - Strobe every 4 cycles; consecutive rd_addr values differ by 4 modulo 256.
- **Abort and restart.**
  - clr asserted during POST: all outputs at reset values the next cycle.
  - arm during WAIT_TRIG: done stays 0, and a fresh PRE of 128 samples precedes any trigger.
- **Read latency.** Step rd_addr every cycle over 0..511 after done: rd_data matches the expected sample exactly 1 cycle later, with no bubbles.
